// File: rtl/dmem_if.sv
// ============================================================================
// dmem_if : request/response bundle between the memory stage and dmem_responder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : fixed-latency byte-addressed data memory, one request at a time
// Optional misalignment trap: define DMEM_MISALIGN_CHECK_EN
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
  parameter int MEM_BYTES = 8192,
  parameter int LATENCY   = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  dmem_if.slave     bus
);

  localparam int         AW     = $clog2(MEM_BYTES);
  localparam logic [3:0] c_last = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic [AW-1:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;

  // Memory is deliberately left out of reset so contents survive rst_n.
  logic [7:0]  r_mem [MEM_BYTES];

  logic [3:0]  w_nbytes;
  logic        w_last;
  logic        w_err;
  logic        w_commit;
  logic [63:0] w_rdata;
  logic        w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[63:AW];

  always_comb begin
    w_nbytes = 4'd1 << r_size;
    w_last   = (r_state == ACCESS) && (r_cnt == c_last);
`ifdef DMEM_MISALIGN_CHECK_EN
    w_err    = (r_addr[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0;
`else
    w_err    = 1'b0;
`endif
    w_commit = w_last && r_write && !w_err;
  end

  // Byte lanes wrap through the top of memory via AW-bit address arithmetic.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(w_nbytes)) begin
        w_rdata[8*i +: 8] = r_mem[r_addr + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(w_nbytes)) begin
          r_mem[r_addr + AW'(i)] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr[AW-1:0];
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'd0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_last) begin
            r_cnt        <= 4'd0;
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (r_write || w_err) ? 64'd0 : w_rdata;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE) && rst_n;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : scoreboard bench with a byte-array reference memory
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  localparam int MEM_BYTES = 8192;
  localparam int LATENCY   = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  dmem_if bus ();

  dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        write;
    bit [1:0]  size;
    bit [63:0] addr;
    bit [63:0] wdata;
    bit [63:0] exp_rdata;
    bit        exp_err;
    int        acc_cyc;
  } txn_t;

  txn_t     q[$];
  bit [7:0] mm [MEM_BYTES];
  int       n_vec = 0;
  int       n_err = 0;
  int       cyc   = 0;
  int       hold  = 0;
  bit       rr_rand = 1'b0;
  bit       b2b_chk = 1'b0;
  int       last_acc = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit [63:0] model_load(input bit [63:0] a, input bit [1:0] sz);
    bit [63:0] d = '0;
    for (int i = 0; i < (1 << sz); i++)
      d[8*i +: 8] = mm[int'((a + 64'(i)) % 64'(MEM_BYTES))];
    return d;
  endfunction

  function automatic void model_store(input bit [63:0] a, input bit [1:0] sz, input bit [63:0] wd);
    for (int i = 0; i < (1 << sz); i++)
      mm[int'((a + 64'(i)) % 64'(MEM_BYTES))] = wd[8*i +: 8];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (hold > 0) begin
      bus.resp_ready = 1'b0;
      hold--;
    end else begin
      bus.resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each presented response against the head of the queue.
  initial begin
    bit        seen    = 1'b0;
    bit        exp_rdy = 1'b0;
    bit [63:0] prev    = '0;
    txn_t      t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen    = 1'b0;
        exp_rdy = 1'b0;
      end else begin
        if (exp_rdy) begin
          chk("req_ready_after_consume", 64'(bus.req_ready), 64'd1);
          exp_rdy = 1'b0;
        end
        if (bus.resp_valid) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: resp_valid 1 with no request outstanding, expected 0");
          end else begin
            t = q[0];
            if (!seen) begin
              chk("resp_latency", 64'(cyc - t.acc_cyc), 64'(LATENCY));
              chk("resp_rdata", bus.resp_rdata, t.exp_rdata);
              chk("resp_err", 64'(bus.resp_err), 64'(t.exp_err));
              prev = bus.resp_rdata;
              seen = 1'b1;
            end else begin
              chk("resp_rdata_hold", bus.resp_rdata, prev);
            end
            chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
            if (bus.resp_ready) begin
              if (t.write && !t.exp_err) model_store(t.addr, t.size, t.wdata);
              void'(q.pop_front());
              seen    = 1'b0;
              exp_rdy = 1'b1;
            end
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input bit w, input bit [1:0] sz, input bit [63:0] a,
                        input bit [63:0] wd, input bit keep);
    txn_t t;
    int   n = 0;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: req_ready 0 for 100 cycles, expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    t.write     = w;
    t.size      = sz;
    t.addr      = a;
    t.wdata     = wd;
    t.exp_err   = MIS_EN && ((a % (64'd1 << sz)) != 64'd0);
    t.exp_rdata = (w || t.exp_err) ? 64'd0 : model_load(a, sz);
    t.acc_cyc   = cyc + 1;
    if (b2b_chk && last_acc >= 0)
      chk("accept_spacing", 64'(t.acc_cyc - last_acc), 64'(LATENCY + 2));
    last_acc = t.acc_cyc;
    q.push_back(t);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d responses still outstanding, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    bit [63:0] a;
    int        off;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 64'd0);
    chk("reset_resp_err", 64'(bus.resp_err), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known contents for the low and top windows used by random traffic.
    for (int i = 0; i < 64; i += 8) do_req(1'b1, 2'd3, 64'(i), {$urandom, $urandom}, 1'b0);
    for (int i = 'h1FC0; i < 'h2000; i += 8) do_req(1'b1, 2'd3, 64'(i), {$urandom, $urandom}, 1'b0);
    drain("prefill");

    do_req(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b0);
    do_req(1'b0, 2'd3, 64'h10, 64'd0, 1'b0);
    do_req(1'b1, 2'd0, 64'h13, 64'hAB, 1'b0);
    do_req(1'b0, 2'd3, 64'h10, 64'd0, 1'b0);
    do_req(1'b0, 2'd1, 64'h12, 64'd0, 1'b0);
    do_req(1'b1, 2'd2, 64'h1FFC, 64'h04030201, 1'b0);
    do_req(1'b1, 2'd2, 64'h0, 64'h08070605, 1'b0);
    do_req(1'b0, 2'd3, 64'h1FFC, 64'd0, 1'b0);
    drain("directed");

    hold = LATENCY + 6;
    do_req(1'b0, 2'd3, 64'h10, 64'd0, 1'b0);
    drain("backpressure");

    do_req(1'b1, 2'd3, 64'h20, 64'd0, 1'b0);
    drain("abort_setup");
    do_req(1'b1, 2'd3, 64'h20, 64'hFFFF, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("abort_resp_rdata", bus.resp_rdata, 64'd0);
    chk("abort_resp_err", 64'(bus.resp_err), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 2'd3, 64'h20, 64'd0, 1'b0);
    drain("abort_check");

    b2b_chk  = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 6; i++)
      do_req(i[0], 2'(i % 4), 64'(8 * i), {$urandom, $urandom}, 1'b1);
    bus.req_valid = 1'b0;
    b2b_chk = 1'b0;
    drain("back_to_back");

    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      off = int'($urandom_range(0, 119));
      a   = {$urandom, $urandom};
      a[12:0] = (off < 56) ? 13'(off) : 13'('h1FC0 + off - 56);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, {$urandom, $urandom}, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_rand = 1'b0;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
